// File: rtl/i2s_frame_scheduler.sv
//------------------------------------------------------------------------------
// Module      : i2s_frame_scheduler
// Description : Buffers 32-bit sample words in a FIFO and schedules them as
//               L/R pairs into I2S slots (ws, bit counter, sd with one-bit
//               delay), with priming, whole-frame underrun muting and stop at
//               frame boundary. Optional status LEDs under `STATUS_LED_EN`.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2s_frame_scheduler #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    serial_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    s_valid,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic                    i2s_ws,
  output logic                    i2s_sd,
  output logic [4:0]              i2s_bit_counter,
  output logic [LVL_W-1:0]        fifo_level,
  output logic                    underrun,
  output logic                    RED_LED,
  output logic                    GREEN_LED,
  output logic                    BLUE_LED
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [LVL_W-1:0]        r_level;

  state_t                  r_state;
  logic [4:0]              r_bit_cnt;
  logic                    r_ws;
  logic                    r_sd;
  logic                    r_underrun;
  logic [SAMPLE_WIDTH-1:0] r_left;
  logic [SAMPLE_WIDTH-1:0] r_right;

  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_can_pair;
  logic                    w_boundary;
  logic                    w_to_run;
  logic                    w_mute;
  logic [LVL_W-1:0]        w_level_next;
  logic [SAMPLE_WIDTH-1:0] w_head_l;
  logic [SAMPLE_WIDTH-1:0] w_head_r;
  logic [SAMPLE_WIDTH-1:0] w_cur_word;

  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push      = s_valid & ~w_full;
  assign w_can_pair  = (r_level >= LVL_W'(2));
  assign w_boundary  = (r_state == ST_RUN) && (r_bit_cnt == 5'd31) && r_ws;
  assign w_to_run    = (r_state == ST_PRIME) && enable && w_can_pair;
  assign w_mute      = w_boundary && enable && !w_can_pair;
  // Pairs are only ever popped together, so the L/R parity of the FIFO is preserved.
  assign w_pop       = w_to_run | (w_boundary & enable & w_can_pair);
  assign w_level_next = r_level + LVL_W'(w_push) - (w_pop ? LVL_W'(2) : LVL_W'(0));
  assign w_head_l    = r_mem[r_rd_ptr];
  assign w_head_r    = r_mem[r_rd_ptr + PTR_W'(1)];
  assign w_cur_word  = r_ws ? r_right : r_left;

  always_ff @(posedge serial_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(2);
      end
      r_level <= w_level_next;
    end
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 5'd0;
      r_ws       <= 1'b0;
      r_sd       <= 1'b0;
      r_underrun <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= 5'd0;
          r_ws      <= 1'b0;
          r_sd      <= 1'b0;
          if (enable) begin
            r_state <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          r_bit_cnt <= 5'd0;
          r_ws      <= 1'b0;
          r_sd      <= 1'b0;
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_can_pair) begin
            r_left  <= w_head_l;
            r_right <= w_head_r;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
          // One-bit I2S delay: counter n carries bit 32-n; the slot LSB spills into the next slot.
          if (r_bit_cnt != 5'd31) begin
            r_sd <= w_cur_word[5'd31 - r_bit_cnt];
          end else if (!r_ws) begin
            r_ws <= 1'b1;
            r_sd <= r_left[0];
          end else if (!enable) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= 5'd0;
            r_ws      <= 1'b0;
            r_sd      <= 1'b0;
          end else begin
            r_ws <= 1'b0;
            r_sd <= r_right[0];
            if (w_can_pair) begin
              r_left  <= w_head_l;
              r_right <= w_head_r;
            end else begin
              r_left     <= '0;
              r_right    <= '0;
              r_underrun <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef STATUS_LED_EN
  logic r_red;
  logic r_green;
  logic r_blue;

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      r_red   <= 1'b0;
      r_green <= 1'b0;
      r_blue  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && enable) begin
        r_red <= 1'b0;
      end else if (w_mute) begin
        r_red <= 1'b1;
      end
      r_green <= ((r_state == ST_RUN) && !(w_boundary && !enable)) || w_to_run;
      r_blue  <= (w_level_next == LVL_W'(FIFO_DEPTH));
    end
  end

  assign RED_LED   = r_red;
  assign GREEN_LED = r_green;
  assign BLUE_LED  = r_blue;
`else
  assign RED_LED   = 1'b0;
  assign GREEN_LED = 1'b0;
  assign BLUE_LED  = 1'b0;
`endif

  assign s_ready         = ~w_full;
  assign fifo_level      = r_level;
  assign i2s_ws          = r_ws;
  assign i2s_sd          = r_sd;
  assign i2s_bit_counter = r_bit_cnt;
  assign underrun        = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_frame_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_i2s_frame_scheduler
// Description : Randomized self-checking bench for i2s_frame_scheduler against
//               a frame-level stream model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2s_frame_scheduler;

  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          serial_clk_tb = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_ready;
  logic          i2s_ws;
  logic          i2s_sd;
  logic [4:0]    i2s_bit_counter;
  logic [LW-1:0] fifo_level;
  logic          underrun;
  logic          RED_LED;
  logic          GREEN_LED;
  logic          BLUE_LED;

  int tests = 0;
  int fails = 0;

  i2s_frame_scheduler #(.SAMPLE_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .serial_clk      (serial_clk_tb),
    .reset           (reset),
    .enable          (enable),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .i2s_ws          (i2s_ws),
    .i2s_sd          (i2s_sd),
    .i2s_bit_counter (i2s_bit_counter),
    .fifo_level      (fifo_level),
    .underrun        (underrun),
    .RED_LED         (RED_LED),
    .GREEN_LED       (GREEN_LED),
    .BLUE_LED        (BLUE_LED)
  );

  always #5 serial_clk_tb = ~serial_clk_tb;

  // Model: word queue plus a queue of expected {ws, counter, sd} per cycle of the current frame.
  logic [31:0] q[$];
  logic [6:0]  stream[$];
  logic [6:0]  e_cur = '0;
  logic        e_und = 1'b0;
  logic        m_red = 1'b0;
  logic [31:0] last_r = '0;
  int          mode = 0;  // 0 idle, 1 prime, 2 run

  task automatic add_frame(input logic prev_lsb, input logic [31:0] l, input logic [31:0] r);
    logic [64:0] s;
    s = {prev_lsb, l, r};
    for (int k = 0; k < 64; k++) begin
      stream.push_back({(k >= 32) ? 1'b1 : 1'b0, 5'(k % 32), s[64-k]});
    end
    last_r = r;
  endtask

  task automatic model_edge(input logic en, input logic vld, input logic [31:0] dat);
    int pre;
    logic [31:0] l, r;
    pre   = q.size();
    e_und = 1'b0;
    case (mode)
      0: begin
        e_cur = '0;
        if (en) begin
          mode  = 1;
          m_red = 1'b0;
        end
      end
      1: begin
        e_cur = '0;
        if (!en) mode = 0;
        else if (pre >= 2) begin
          l = q.pop_front();
          r = q.pop_front();
          add_frame(1'b0, l, r);
          e_cur = stream.pop_front();
          mode  = 2;
        end
      end
      default: begin
        if (stream.size() > 0) e_cur = stream.pop_front();
        else if (!en) begin
          mode  = 0;
          e_cur = '0;
        end else begin
          if (pre >= 2) begin
            l = q.pop_front();
            r = q.pop_front();
          end else begin
            l = '0;
            r = '0;
            e_und = 1'b1;
            m_red = 1'b1;
          end
          add_frame(last_r[0], l, r);
          e_cur = stream.pop_front();
        end
      end
    endcase
    if (vld && pre < DEPTH) q.push_back(dat);
  endtask

  task automatic model_reset();
    q.delete();
    stream.delete();
    e_cur  = '0;
    e_und  = 1'b0;
    m_red  = 1'b0;
    last_r = '0;
    mode   = 0;
  endtask

  function automatic logic [15:0] exp_vec();
    logic [2:0] leds;
`ifdef STATUS_LED_EN
    leds = {m_red, (mode == 2) ? 1'b1 : 1'b0, (q.size() == DEPTH) ? 1'b1 : 1'b0};
`else
    leds = 3'b000;
`endif
    return {e_cur, e_und, LW'(q.size()), (q.size() < DEPTH) ? 1'b1 : 1'b0, leds};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {i2s_ws, i2s_bit_counter, i2s_sd, underrun, fifo_level, s_ready,
            RED_LED, GREEN_LED, BLUE_LED};
  endfunction

  task automatic step(input logic en, input logic vld, input logic [31:0] dat);
    enable  = en;
    s_valid = vld;
    s_data  = dat;
    @(posedge serial_clk_tb);
    model_edge(en, vld, dat);
    #1;
  endtask

  function automatic logic rnd_push(input int rate);
    return ($urandom_range(0, rate - 1) == 0);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge serial_clk_tb);
    #1;
    model_reset();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_hold got=%h exp=%h", obs_vec(), exp_vec());
    end
    @(negedge serial_clk_tb);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] words [4];
    words[0] = 32'hFFFF_FFFF;
    words[1] = 32'hFFFF_FFFF;
    words[2] = 32'h8000_0001;
    words[3] = 32'h0000_0000;
    for (int i = 0; i < 260; i++) begin
      if (i < 4) step(1'b1, 1'b1, words[i]);
      else       step(1'b1, 1'b0, '0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL directed cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stop();
    int guard;
    guard = 0;
    while (!(mode == 2 && e_cur[6:1] == {1'b0, 5'd10}) && guard < 300) begin
      step(1'b1, rnd_push(20), $urandom);
      guard++;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stop_seek cyc=%0d got=%h exp=%h", guard, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (guard >= 300) begin
      fails++;
      $display("FAIL stop_timeout got=%0d required<300", guard);
    end
    for (int i = 0; i < 120; i++) begin
      step(1'b0, 1'b0, '0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stop cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 14; i++) begin
      step(1'b0, (i < 10) ? 1'b1 : 1'b0, $urandom);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL full cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stream_random();
    int rate;
    for (int i = 0; i < 900; i++) begin
      rate = (i < 450) ? 12 : 60;
      step((i % 300) < 280 ? 1'b1 : ($urandom_range(0, 1) == 1), rnd_push(rate), $urandom);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    while (!(mode == 2 && e_cur[6:1] == {1'b1, 5'd17}) && guard < 400) begin
      step(1'b1, rnd_push(10), $urandom);
      guard++;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL mreset_seek cyc=%0d got=%h exp=%h", guard, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (guard >= 400) begin
      fails++;
      $display("FAIL mreset_timeout got=%0d required<400", guard);
    end
    #2;
    enable  = 1'b0;
    s_valid = 1'b0;
    reset   = 1'b0;
    #1;
    model_reset();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL mreset_async got=%h exp=%h", obs_vec(), exp_vec());
    end
    @(negedge serial_clk_tb);
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, (i < 4) ? 1'b1 : rnd_push(40), $urandom);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL mreset_after cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stop();
    test_full();
    test_stream_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
